// File: rtl/thread_fetch.sv
// thread_fetch: four-thread round-robin instruction fetch stage.
// Each thread owns a PC. One runnable thread is picked per cycle, starting
// the scan just after the thread picked last. Execute-stage redirects and
// halts are merged here, and a one-entry registered fetch slot feeds imem.
module thread_fetch #(
  parameter int INSTMEM_LOG2_DEEP = 8,
  parameter int THREAD_BASE_0     = 0,
  parameter int THREAD_BASE_1     = 64,
  parameter int THREAD_BASE_2     = 128,
  parameter int THREAD_BASE_3     = 192
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         en_i,
  input  logic                         stall_i,
  input  logic [3:0]                   thread_active_i,
  input  logic                         redir_valid_i,
  input  logic [1:0]                   redir_thread_i,
  input  logic [INSTMEM_LOG2_DEEP-1:0] redir_pc_i,
  input  logic                         halt_valid_i,
  input  logic [1:0]                   halt_thread_i,
  output logic [INSTMEM_LOG2_DEEP-1:0] imem_addr_o,
  output logic                         valid_o,
  output logic [1:0]                   thread_id_o,
  output logic [INSTMEM_LOG2_DEEP-1:0] pc_carry_baggage_o,
  output logic [3:0]                   thread_done_o
);

  localparam int AW = INSTMEM_LOG2_DEEP;
  localparam logic [AW-1:0] PC_ONE  = AW'(1);
  localparam logic [AW-1:0] PC_ZERO = AW'(0);

  // Reset PC of each thread; the default arm is never reached for a 2-bit id.
  function automatic logic [AW-1:0] base_pc(input logic [1:0] tid);
    logic [AW-1:0] res;
    case (tid)
      2'd0:    res = AW'(THREAD_BASE_0);
      2'd1:    res = AW'(THREAD_BASE_1);
      2'd2:    res = AW'(THREAD_BASE_2);
      2'd3:    res = AW'(THREAD_BASE_3);
      default: res = AW'(THREAD_BASE_0);
    endcase
    return res;
  endfunction

  // Round-robin pick: scan last+1 .. last+4 (mod 4), return {found, thread}.
  function automatic logic [2:0] rr_pick(input logic [3:0] run, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!res[2] && run[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // State registers.
  logic [AW-1:0] pc_q [4];
  logic [AW-1:0] pc_d [4];
  logic [3:0]    done_q;
  logic [3:0]    done_d;
  logic [1:0]    rr_last_q;
  logic [1:0]    rr_last_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] bag_q;
  logic [AW-1:0] bag_d;
  logic [1:0]    tid_q;
  logic [1:0]    tid_d;
  logic          valid_q;
  logic          valid_d;

  // Combinational helpers.
  logic [3:0]    halt_dec_s;
  logic [3:0]    redir_dec_s;
  logic [3:0]    runnable_s;
  logic [2:0]    pick_s;
  logic [1:0]    sel_s;
  logic          any_run_s;
  logic          issue_s;
  logic [AW-1:0] eff_pc_s;
  logic [AW-1:0] eff_pc_inc_s;
  logic          squash_s;

  // Decode halts/redirects, compute runnable set, pick a thread and its effective PC.
  always_comb begin
    halt_dec_s  = 4'b0000;
    redir_dec_s = 4'b0000;
    if (halt_valid_i) begin
      halt_dec_s = 4'b0001 << halt_thread_i;
    end else begin
      halt_dec_s = 4'b0000;
    end
    if (redir_valid_i) begin
      redir_dec_s = 4'b0001 << redir_thread_i;
    end else begin
      redir_dec_s = 4'b0000;
    end
    // A thread halting this cycle is already ineligible.
    runnable_s = thread_active_i & ~done_q & ~halt_dec_s;
    pick_s     = rr_pick(runnable_s, rr_last_q);
    any_run_s  = pick_s[2];
    sel_s      = pick_s[1:0];
    issue_s    = en_i & ~stall_i & any_run_s;
    if (redir_dec_s[sel_s]) begin
      eff_pc_s = redir_pc_i;
    end else begin
      eff_pc_s = pc_q[sel_s];
    end
    eff_pc_inc_s = eff_pc_s + PC_ONE;
    // A redirect to the owner of a held fetch invalidates that fetch.
    squash_s = valid_q & redir_valid_i & (redir_thread_i == tid_q);
  end

  // Next-state: issue, stall hold/squash, idle bubble, PC and done updates.
  always_comb begin
    addr_d    = addr_q;
    bag_d     = bag_q;
    tid_d     = tid_q;
    valid_d   = valid_q;
    rr_last_d = rr_last_q;
    done_d    = done_q | halt_dec_s;
    for (int n = 0; n < 4; n++) begin
      pc_d[n] = pc_q[n];
    end

    // Redirect writes land even when that thread is not issued this cycle.
    for (int n = 0; n < 4; n++) begin
      if (redir_dec_s[n]) begin
        pc_d[n] = redir_pc_i;
      end else begin
        pc_d[n] = pc_q[n];
      end
    end

    if (issue_s) begin
      addr_d    = eff_pc_s;
      bag_d     = eff_pc_inc_s;
      tid_d     = sel_s;
      valid_d   = 1'b1;
      rr_last_d = sel_s;
      // The issued thread advances past its effective PC (overrides redirect write).
      for (int n = 0; n < 4; n++) begin
        if (sel_s == 2'(n)) begin
          pc_d[n] = eff_pc_inc_s;
        end else begin
          pc_d[n] = pc_d[n];
        end
      end
    end else if (stall_i) begin
      if (squash_s) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      // Not stalled but nothing to issue: bubble.
      valid_d = 1'b0;
    end
  end

  // State update with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int n = 0; n < 4; n++) begin
        pc_q[n] <= base_pc(2'(n));
      end
      done_q    <= 4'b0000;
      rr_last_q <= 2'd3;
      addr_q    <= PC_ZERO;
      bag_q     <= PC_ZERO;
      tid_q     <= 2'd0;
      valid_q   <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        pc_q[n] <= pc_d[n];
      end
      done_q    <= done_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      bag_q     <= bag_d;
      tid_q     <= tid_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_addr_o        = addr_q;
  assign pc_carry_baggage_o = bag_q;
  assign thread_id_o        = tid_q;
  assign valid_o            = valid_q;
  assign thread_done_o      = done_q;

endmodule

// File: tb/tb_thread_fetch.sv
// Directed self-checking bench for thread_fetch (default parameters).
module tb_thread_fetch;

  logic       CLK;
  logic       RST;
  logic       en_i;
  logic       stall_i;
  logic [3:0] thread_active_i;
  logic       redir_valid_i;
  logic [1:0] redir_thread_i;
  logic [7:0] redir_pc_i;
  logic       halt_valid_i;
  logic [1:0] halt_thread_i;
  logic [7:0] imem_addr_o;
  logic       valid_o;
  logic [1:0] thread_id_o;
  logic [7:0] pc_carry_baggage_o;
  logic [3:0] thread_done_o;

  int errors = 0;
  int checks = 0;

  // Observed fetch slot packed as {valid, thread, addr, baggage}.
  logic [18:0] obs_s;
  assign obs_s = {valid_o, thread_id_o, imem_addr_o, pc_carry_baggage_o};

  thread_fetch dut (
    .CLK                (CLK),
    .RST                (RST),
    .en_i               (en_i),
    .stall_i            (stall_i),
    .thread_active_i    (thread_active_i),
    .redir_valid_i      (redir_valid_i),
    .redir_thread_i     (redir_thread_i),
    .redir_pc_i         (redir_pc_i),
    .halt_valid_i       (halt_valid_i),
    .halt_thread_i      (halt_thread_i),
    .imem_addr_o        (imem_addr_o),
    .valid_o            (valid_o),
    .thread_id_o        (thread_id_o),
    .pc_carry_baggage_o (pc_carry_baggage_o),
    .thread_done_o      (thread_done_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    en_i            = 1'b0;
    stall_i         = 1'b0;
    thread_active_i = 4'b0000;
    redir_valid_i   = 1'b0;
    redir_thread_i  = 2'd0;
    redir_pc_i      = 8'd0;
    halt_valid_i    = 1'b0;
    halt_thread_i   = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2;
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    #3;
    RST = 1'b0;
    #1;
    checks++;
    if (obs_s !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", obs_s, 19'd0);
    end
    checks++;
    if (thread_done_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_done got %b want %b", thread_done_o, 4'b0000);
    end
    tick();
    RST = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] et [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] ea [6] = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd1, 8'd65};
    do_reset();
    en_i = 1'b1;
    thread_active_i = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs_s !== {1'b1, et[i], ea[i], ea[i] + 8'd1}) begin
        errors++;
        $display("FAIL rr_seq step %0d got %h want %h", i, obs_s, {1'b1, et[i], ea[i], ea[i] + 8'd1});
      end
    end
  endtask

  task automatic test_mask();
    logic [1:0] et [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [7:0] ea [4] = '{8'd0, 8'd128, 8'd1, 8'd129};
    do_reset();
    en_i = 1'b1;
    thread_active_i = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_s !== {1'b1, et[i], ea[i], ea[i] + 8'd1}) begin
        errors++;
        $display("FAIL mask_seq step %0d got %h want %h", i, obs_s, {1'b1, et[i], ea[i], ea[i] + 8'd1});
      end
    end
    // en_i low: bubble, other outputs hold.
    en_i = 1'b0;
    tick();
    checks++;
    if (obs_s !== {1'b0, 2'd2, 8'd129, 8'd130}) begin
      errors++;
      $display("FAIL en_off got %h want %h", obs_s, {1'b0, 2'd2, 8'd129, 8'd130});
    end
    // Re-enable all threads: thread 1/3 PCs preserved at their bases.
    en_i = 1'b1;
    thread_active_i = 4'b1111;
    tick();
    checks++;
    if (obs_s !== {1'b1, 2'd3, 8'd192, 8'd193}) begin
      errors++;
      $display("FAIL mask_reenable3 got %h want %h", obs_s, {1'b1, 2'd3, 8'd192, 8'd193});
    end
    tick();
    tick();
    checks++;
    if (obs_s !== {1'b1, 2'd1, 8'd64, 8'd65}) begin
      errors++;
      $display("FAIL mask_reenable1 got %h want %h", obs_s, {1'b1, 2'd1, 8'd64, 8'd65});
    end
  endtask

  task automatic test_stall();
    logic [1:0] et [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] ea [4] = '{8'd128, 8'd192, 8'd1, 8'd65};
    do_reset();
    en_i = 1'b1;
    thread_active_i = 4'b1111;
    tick();
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_s !== {1'b1, 2'd1, 8'd64, 8'd65}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got %h want %h", i, obs_s, {1'b1, 2'd1, 8'd64, 8'd65});
      end
    end
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_s !== {1'b1, et[i], ea[i], ea[i] + 8'd1}) begin
        errors++;
        $display("FAIL stall_resume step %0d got %h want %h", i, obs_s, {1'b1, et[i], ea[i], ea[i] + 8'd1});
      end
    end
  endtask

  task automatic test_redirect();
    logic [1:0] et [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] ea [4] = '{8'd128, 8'd192, 8'd1, 8'h21};
    logic [1:0] ft [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] fa [4] = '{8'd129, 8'd193, 8'd2, 8'h40};
    do_reset();
    en_i = 1'b1;
    thread_active_i = 4'b1111;
    tick();
    redir_valid_i  = 1'b1;
    redir_thread_i = 2'd1;
    redir_pc_i     = 8'h20;
    tick();
    redir_valid_i = 1'b0;
    checks++;
    if (obs_s !== {1'b1, 2'd1, 8'h20, 8'h21}) begin
      errors++;
      $display("FAIL redir_issue got %h want %h", obs_s, {1'b1, 2'd1, 8'h20, 8'h21});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_s !== {1'b1, et[i], ea[i], ea[i] + 8'd1}) begin
        errors++;
        $display("FAIL redir_follow step %0d got %h want %h", i, obs_s, {1'b1, et[i], ea[i], ea[i] + 8'd1});
      end
    end
    // Stalled with thread 1 in the slot: redirect squashes it and rewrites PC[1].
    stall_i        = 1'b1;
    redir_valid_i  = 1'b1;
    redir_thread_i = 2'd1;
    redir_pc_i     = 8'h40;
    tick();
    stall_i       = 1'b0;
    redir_valid_i = 1'b0;
    checks++;
    if (obs_s !== {1'b0, 2'd1, 8'h21, 8'h22}) begin
      errors++;
      $display("FAIL redir_squash got %h want %h", obs_s, {1'b0, 2'd1, 8'h21, 8'h22});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_s !== {1'b1, ft[i], fa[i], fa[i] + 8'd1}) begin
        errors++;
        $display("FAIL redir_after_squash step %0d got %h want %h", i, obs_s, {1'b1, ft[i], fa[i], fa[i] + 8'd1});
      end
    end
  endtask

  task automatic test_halt();
    logic       hv [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] ht [9] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0};
    logic       ev [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] et [9] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
    logic [7:0] ea [9] = '{8'd0, 8'd64, 8'd192, 8'd1, 8'd65, 8'd193, 8'd194, 8'd194, 8'd194};
    do_reset();
    en_i = 1'b1;
    thread_active_i = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      halt_valid_i  = hv[i];
      halt_thread_i = ht[i];
      tick();
      checks++;
      if (obs_s !== {ev[i], et[i], ea[i], ea[i] + 8'd1}) begin
        errors++;
        $display("FAIL halt_seq step %0d got %h want %h", i, obs_s, {ev[i], et[i], ea[i], ea[i] + 8'd1});
      end
    end
    halt_valid_i = 1'b0;
    checks++;
    if (thread_done_o !== 4'b1111) begin
      errors++;
      $display("FAIL halt_done got %b want %b", thread_done_o, 4'b1111);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    en_i = 1'b1;
    thread_active_i = 4'b0001;
    redir_valid_i  = 1'b1;
    redir_thread_i = 2'd0;
    redir_pc_i     = 8'd255;
    tick();
    redir_valid_i = 1'b0;
    checks++;
    if (obs_s !== {1'b1, 2'd0, 8'd255, 8'd0}) begin
      errors++;
      $display("FAIL wrap_issue got %h want %h", obs_s, {1'b1, 2'd0, 8'd255, 8'd0});
    end
    tick();
    checks++;
    if (obs_s !== {1'b1, 2'd0, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL wrap_next got %h want %h", obs_s, {1'b1, 2'd0, 8'd0, 8'd1});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en_i = 1'b1;
    thread_active_i = 4'b1111;
    tick();
    tick();
    tick();
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (obs_s !== 19'd0) begin
      errors++;
      $display("FAIL async_reset got %h want %h", obs_s, 19'd0);
    end
    #1;
    RST = 1'b1;
    tick();
    checks++;
    if (obs_s !== {1'b1, 2'd0, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL async_restart0 got %h want %h", obs_s, {1'b1, 2'd0, 8'd0, 8'd1});
    end
    tick();
    checks++;
    if (obs_s !== {1'b1, 2'd1, 8'd64, 8'd65}) begin
      errors++;
      $display("FAIL async_restart1 got %h want %h", obs_s, {1'b1, 2'd1, 8'd64, 8'd65});
    end
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_mask();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
